// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the parallel-in / serial-out serializer.
package piso_serializer_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Bits needed to hold values 0..v-1, never less than one.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = 32'(i + 1);
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Load-side and serial-link handshake bundle for the serializer.
interface piso_serializer_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] d;
    logic             load_valid;
    logic             load_ready;
    logic             sout;
    logic             sout_valid;
    logic             sout_ready;
    logic             sout_last;
    logic             busy;

    // Environment side: upstream word source plus serial sink.
    modport master (
        output d, load_valid, sout_ready,
        input  load_ready, sout, sout_valid, sout_last, busy
    );

    // Serializer side.
    modport slave (
        input  d, load_valid, sout_ready,
        output load_ready, sout, sout_valid, sout_last, busy
    );
endinterface

// File: rtl/piso_serializer_bit_counter.sv
// Remaining-bit counter: loads WIDTH-1, counts down on each beat, flags zero.
module piso_serializer_bit_counter
    import piso_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic beat,
    output logic zero
);
    localparam int unsigned CNT_W = clog2(WIDTH);

    logic [CNT_W-1:0] cnt;

    // Load wins over a same-cycle beat; count holds at zero on the last bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(WIDTH - 1);
        end else if (beat && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/piso_serializer.sv
// Serializes a parallel word one bit per accepted beat, with zero-bubble reload.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    piso_serializer_if.slave    bus
);
    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] sreg_q;
    logic             in_shift;
    logic             cnt_zero;
    logic             beat;
    logic             load;
    logic             out_bit;

    piso_serializer_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .beat (beat),
        .zero (cnt_zero)
    );

    // Outputs come from state; load_ready also sees sout_ready so the last
    // beat and the next load can share a cycle. rst forces all outputs low.
    always_comb begin
        state_d        = state_q;
        in_shift       = (state_q == ST_SHIFT) && !rst;
        out_bit        = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
        bus.sout_valid = in_shift;
        bus.sout       = in_shift && out_bit;
        bus.sout_last  = in_shift && cnt_zero;
        bus.busy       = in_shift;
        bus.load_ready = !rst && ((state_q == ST_IDLE) || (cnt_zero && bus.sout_ready));
        beat           = in_shift && bus.sout_ready;
        load           = bus.load_valid && bus.load_ready;
        if (load) begin
            state_d = ST_SHIFT;
        end else if (beat && cnt_zero) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                sreg_q <= bus.d;
            end else if (beat && !cnt_zero) begin
                sreg_q <= MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB-first and LSB-first instances.
module tb_piso_serializer;

    typedef struct packed {
        logic lr;
        logic sout;
        logic sv;
        logic last;
        logic busy;
    } out_t;

    typedef struct {
        logic       rst;
        logic [3:0] d;
        logic       lv;
        logic       sr;
        out_t       exp;
    } vec_t;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    piso_serializer_if #(.WIDTH(4)) m_if ();
    piso_serializer_if #(.WIDTH(4)) l_if ();

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clk (clk),
        .rst (rst),
        .bus (m_if)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk (clk),
        .rst (rst),
        .bus (l_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t o(input logic lr, input logic s, input logic v,
                               input logic l, input logic b);
        out_t r;
        r.lr = lr; r.sout = s; r.sv = v; r.last = l; r.busy = b;
        return r;
    endfunction

    function automatic vec_t mk(input logic r, input logic [3:0] d, input logic lv,
                                input logic sr, input out_t e);
        vec_t v;
        v.rst = r; v.d = d; v.lv = lv; v.sr = sr; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input out_t act, input out_t exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got lr,sout,valid,last,busy=%b required %b", name, act, exp);
    endtask

    // Drive one cycle on the MSB-first instance and check outputs before the edge.
    task automatic step_m(input string name, input logic r, input logic [3:0] d,
                          input logic lv, input logic sr, input out_t exp);
        @(negedge clk);
        rst = r; m_if.d = d; m_if.load_valid = lv; m_if.sout_ready = sr;
        #1;
        check(name, out_t'({m_if.load_ready, m_if.sout, m_if.sout_valid,
                            m_if.sout_last, m_if.busy}), exp);
    endtask

    task automatic step_l(input string name, input logic [3:0] d,
                          input logic lv, input logic sr, input out_t exp);
        @(negedge clk);
        l_if.d = d; l_if.load_valid = lv; l_if.sout_ready = sr;
        #1;
        check(name, out_t'({l_if.load_ready, l_if.sout, l_if.sout_valid,
                            l_if.sout_last, l_if.busy}), exp);
    endtask

    vec_t vecs[27];
    out_t idle_o;

    initial begin
        n_pass = 0;
        n_total = 0;
        rst = 1'b1;
        m_if.d = '0; m_if.load_valid = 1'b0; m_if.sout_ready = 1'b0;
        l_if.d = '0; l_if.load_valid = 1'b0; l_if.sout_ready = 1'b0;
        idle_o = o(1, 0, 0, 0, 0);

        // reset, then idle
        vecs[0]  = mk(1, 4'b0000, 0, 0, o(0, 0, 0, 0, 0));
        vecs[1]  = mk(1, 4'b0000, 0, 0, o(0, 0, 0, 0, 0));
        vecs[2]  = mk(0, 4'b0000, 0, 0, idle_o);
        // 1011 MSB-first, sink always ready
        vecs[3]  = mk(0, 4'b1011, 1, 1, idle_o);
        vecs[4]  = mk(0, 4'b0000, 0, 1, o(0, 1, 1, 0, 1));
        vecs[5]  = mk(0, 4'b0000, 0, 1, o(0, 0, 1, 0, 1));
        vecs[6]  = mk(0, 4'b0000, 0, 1, o(0, 1, 1, 0, 1));
        vecs[7]  = mk(0, 4'b0000, 0, 1, o(1, 1, 1, 1, 1));
        vecs[8]  = mk(0, 4'b0000, 0, 1, idle_o);
        // 0110 with three stalled cycles on the first bit
        vecs[9]  = mk(0, 4'b0110, 1, 0, idle_o);
        vecs[10] = mk(0, 4'b0000, 0, 0, o(0, 0, 1, 0, 1));
        vecs[11] = mk(0, 4'b0000, 0, 0, o(0, 0, 1, 0, 1));
        vecs[12] = mk(0, 4'b0000, 0, 0, o(0, 0, 1, 0, 1));
        vecs[13] = mk(0, 4'b0000, 0, 1, o(0, 0, 1, 0, 1));
        vecs[14] = mk(0, 4'b0000, 0, 1, o(0, 1, 1, 0, 1));
        vecs[15] = mk(0, 4'b0000, 0, 1, o(0, 1, 1, 0, 1));
        vecs[16] = mk(0, 4'b0000, 0, 1, o(1, 0, 1, 1, 1));
        // back-to-back 0001 then 1000, load_valid held through the first word
        vecs[17] = mk(0, 4'b0001, 1, 1, idle_o);
        vecs[18] = mk(0, 4'b1000, 1, 1, o(0, 0, 1, 0, 1));
        vecs[19] = mk(0, 4'b1000, 1, 1, o(0, 0, 1, 0, 1));
        vecs[20] = mk(0, 4'b1000, 1, 1, o(0, 0, 1, 0, 1));
        vecs[21] = mk(0, 4'b1000, 1, 1, o(1, 1, 1, 1, 1));
        vecs[22] = mk(0, 4'b0000, 0, 1, o(0, 1, 1, 0, 1));
        vecs[23] = mk(0, 4'b0000, 0, 1, o(0, 0, 1, 0, 1));
        vecs[24] = mk(0, 4'b0000, 0, 1, o(0, 0, 1, 0, 1));
        vecs[25] = mk(0, 4'b0000, 0, 1, o(1, 0, 1, 1, 1));
        vecs[26] = mk(0, 4'b0000, 0, 1, idle_o);

        for (int i = 0; i < 27; i++) begin
            step_m($sformatf("vec%0d", i), vecs[i].rst, vecs[i].d, vecs[i].lv,
                   vecs[i].sr, vecs[i].exp);
        end

        // LSB-first instance shared the reset and stayed idle throughout
        step_l("lsb_idle", 4'b0000, 0, 0, idle_o);

        // reset in the middle of 1111, then a clean 0100
        step_m("rst_load",  0, 4'b1111, 1, 1, idle_o);
        step_m("rst_beat1", 0, 4'b0000, 0, 1, o(0, 1, 1, 0, 1));
        step_m("rst_beat2", 0, 4'b0000, 0, 1, o(0, 1, 1, 0, 1));
        step_m("rst_hold",  1, 4'b0000, 0, 1, o(0, 0, 0, 0, 0));
        step_m("rst_after", 0, 4'b0000, 0, 1, idle_o);
        step_m("w2_load",   0, 4'b0100, 1, 1, idle_o);
        step_m("w2_b1",     0, 4'b0000, 0, 1, o(0, 0, 1, 0, 1));
        step_m("w2_b2",     0, 4'b0000, 0, 1, o(0, 1, 1, 0, 1));
        step_m("w2_b3",     0, 4'b0000, 0, 1, o(0, 0, 1, 0, 1));
        step_m("w2_b4",     0, 4'b0000, 0, 1, o(1, 0, 1, 1, 1));
        step_m("w2_idle",   0, 4'b0000, 0, 1, idle_o);

        // LSB-first 0010; a competing 1111 offered while stalled must be ignored
        step_l("lsb_load",   4'b0010, 1, 1, idle_o);
        step_l("lsb_stall1", 4'b1111, 1, 0, o(0, 0, 1, 0, 1));
        step_l("lsb_stall2", 4'b1111, 1, 0, o(0, 0, 1, 0, 1));
        step_l("lsb_b1",     4'b0000, 0, 1, o(0, 0, 1, 0, 1));
        step_l("lsb_b2",     4'b0000, 0, 1, o(0, 1, 1, 0, 1));
        step_l("lsb_b3",     4'b0000, 0, 1, o(0, 0, 1, 0, 1));
        step_l("lsb_b4",     4'b0000, 0, 1, o(1, 0, 1, 1, 1));
        step_l("lsb_idle2",  4'b0000, 0, 1, idle_o);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
